// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that shares one DDR2 command port between the cache (port 0) and the DVI engine (port 1).
// Optional BUSY watchdog enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int ADDR_W         = 28,
  parameter int DATA_W         = 256,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic              req0_rw,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wr_data,
  output logic [DATA_W-1:0] req0_rd_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic              req1_rw,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wr_data,
  output logic [DATA_W-1:0] req1_rd_data,
  output logic              req1_ready,
  output logic [ADDR_W-1:0] mem_data_addr,
  output logic [DATA_W-1:0] mem_data_wr,
  output logic              mem_rw_data,
  output logic              mem_valid_data,
  input  logic [DATA_W-1:0] mem_data_rd,
  input  logic              mem_ready_data,
  output logic [1:0]        gnt,
  output logic              error
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state;
  logic   last_grant;
  logic   winner;

`ifdef ARB_TIMEOUT_EN
  logic [7:0] timeout_cnt;
`else
  logic [7:0] unused_timeout_cfg;
  assign unused_timeout_cfg = 8'(TIMEOUT_CYCLES);
  assign error = 1'b0;
`endif

  // On a tie the port that did not win last time gets the grant.
  always_comb begin
    winner = req1_valid;
    if (req0_valid && req1_valid) winner = ~last_grant;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      last_grant     <= 1'b1;
      gnt            <= 2'b00;
      mem_data_addr  <= '0;
      mem_data_wr    <= '0;
      mem_rw_data    <= 1'b0;
      mem_valid_data <= 1'b0;
      req0_ready     <= 1'b0;
      req1_ready     <= 1'b0;
      req0_rd_data   <= '0;
      req1_rd_data   <= '0;
`ifdef ARB_TIMEOUT_EN
      timeout_cnt    <= '0;
      error          <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req0_valid || req1_valid) begin
            mem_data_addr  <= winner ? req1_addr    : req0_addr;
            mem_data_wr    <= winner ? req1_wr_data : req0_wr_data;
            mem_rw_data    <= winner ? req1_rw      : req0_rw;
            mem_valid_data <= 1'b1;
            gnt            <= winner ? 2'b10 : 2'b01;
            last_grant     <= winner;
            state          <= BUSY;
`ifdef ARB_TIMEOUT_EN
            timeout_cnt    <= '0;
`endif
          end
        end
        BUSY: begin
          if (mem_ready_data) begin
            if (!mem_rw_data) begin
              if (gnt[1]) req1_rd_data <= mem_data_rd;
              else        req0_rd_data <= mem_data_rd;
            end
            mem_valid_data <= 1'b0;
            mem_rw_data    <= 1'b0;
            req0_ready     <= gnt[0];
            req1_ready     <= gnt[1];
            state          <= DONE;
          end
`ifdef ARB_TIMEOUT_EN
          // Abort a stuck transaction: the owner still sees a ready, with zeroed data.
          else if (timeout_cnt == 8'(TIMEOUT_CYCLES - 1)) begin
            if (gnt[1]) req1_rd_data <= '0;
            else        req0_rd_data <= '0;
            mem_valid_data <= 1'b0;
            mem_rw_data    <= 1'b0;
            req0_ready     <= gnt[0];
            req1_ready     <= gnt[1];
            error          <= 1'b1;
            state          <= DONE;
          end else begin
            timeout_cnt <= timeout_cnt + 8'd1;
          end
`endif
        end
        DONE: begin
          req0_ready <= 1'b0;
          req1_ready <= 1'b0;
          gnt        <= 2'b00;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table for single transactions plus
// hand-written contention, reset-in-flight and watchdog sequences.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 28;
  localparam int DATA_W = 256;

  localparam logic [ADDR_W-1:0] A0  = 28'h0FF1000;
  localparam logic [ADDR_W-1:0] A1  = 28'h3FF1040;
  localparam logic [DATA_W-1:0] D0  = {8{32'hDEADBEF0}};
  localparam logic [DATA_W-1:0] R1  = {{31{8'h11}}, 8'hF8};
  localparam logic [DATA_W-1:0] R2  = {8{32'hA5A55A5A}};
  localparam logic [DATA_W-1:0] BAD = {8{32'hBAADF00D}};
  localparam logic [DATA_W-1:0] Z   = '0;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req0_valid, req0_rw, req1_valid, req1_rw;
  logic [ADDR_W-1:0] req0_addr, req1_addr;
  logic [DATA_W-1:0] req0_wr_data, req1_wr_data;
  logic [DATA_W-1:0] req0_rd_data, req1_rd_data;
  logic              req0_ready, req1_ready;
  logic [ADDR_W-1:0] mem_data_addr;
  logic [DATA_W-1:0] mem_data_wr, mem_data_rd;
  logic              mem_rw_data, mem_valid_data, mem_ready_data;
  logic [1:0]        gnt;
  logic              error;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic              r0v;
    logic              r0rw;
    logic [ADDR_W-1:0] r0a;
    logic [DATA_W-1:0] r0wd;
    logic              r1v;
    logic              r1rw;
    logic [ADDR_W-1:0] r1a;
    logic [DATA_W-1:0] r1wd;
    logic              mrdy;
    logic [DATA_W-1:0] mrd;
    logic [1:0]        e_gnt;
    logic              e_mv;
    logic              e_mrw;
    logic [ADDR_W-1:0] e_ma;
    logic [DATA_W-1:0] e_mwd;
    logic              e_r0rdy;
    logic              e_r1rdy;
    logic [DATA_W-1:0] e_r0rd;
    logic [DATA_W-1:0] e_r1rd;
  } vec_t;

  vec_t vecs [14];

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(255)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_rw(req0_rw), .req0_addr(req0_addr),
    .req0_wr_data(req0_wr_data), .req0_rd_data(req0_rd_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_rw(req1_rw), .req1_addr(req1_addr),
    .req1_wr_data(req1_wr_data), .req1_rd_data(req1_rd_data), .req1_ready(req1_ready),
    .mem_data_addr(mem_data_addr), .mem_data_wr(mem_data_wr), .mem_rw_data(mem_rw_data),
    .mem_valid_data(mem_valid_data), .mem_data_rd(mem_data_rd),
    .mem_ready_data(mem_ready_data), .gnt(gnt), .error(error)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [DATA_W-1:0] act,
                             input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    req0_valid     = v.r0v;
    req0_rw        = v.r0rw;
    req0_addr      = v.r0a;
    req0_wr_data   = v.r0wd;
    req1_valid     = v.r1v;
    req1_rw        = v.r1rw;
    req1_addr      = v.r1a;
    req1_wr_data   = v.r1wd;
    mem_ready_data = v.mrdy;
    mem_data_rd    = v.mrd;
  endtask

  initial begin
    int   ng;
    int   last_rise;
    logic prev_v;
    logic [1:0] order [4];
    logic bad;
    logic got;

    // Field order: inputs (r0v r0rw r0a r0wd r1v r1rw r1a r1wd mrdy mrd), then
    // expected (gnt mv mrw ma mwd r0rdy r1rdy r0rd r1rd).
    for (int i = 0; i < 5; i++)
      vecs[i] = '{1, 1, A0, D0, 0, 0, 0, Z, 0, Z,     2'b01, 1, 1, A0, D0, 0, 0, Z, Z};
    vecs[5]  = '{1, 1, A0, D0, 0, 0, 0, Z, 1, BAD,    2'b01, 0, 0, A0, D0, 1, 0, Z, Z};
    vecs[6]  = '{0, 0, 0, Z, 0, 0, 0, Z, 0, Z,        2'b00, 0, 0, A0, D0, 0, 0, Z, Z};
    vecs[7]  = '{0, 0, 0, Z, 0, 0, 0, Z, 0, Z,        2'b00, 0, 0, A0, D0, 0, 0, Z, Z};
    vecs[8]  = '{0, 0, 0, Z, 1, 0, A1, Z, 0, Z,       2'b10, 1, 0, A1, Z, 0, 0, Z, Z};
    vecs[9]  = '{0, 0, 0, Z, 1, 0, A1, Z, 0, Z,       2'b10, 1, 0, A1, Z, 0, 0, Z, Z};
    vecs[10] = '{0, 0, 0, Z, 1, 0, A1, Z, 1, R1,      2'b10, 0, 0, A1, Z, 0, 1, Z, R1};
    vecs[11] = '{0, 0, 0, Z, 0, 0, 0, Z, 0, Z,        2'b00, 0, 0, A1, Z, 0, 0, Z, R1};
    vecs[12] = '{0, 0, 0, Z, 0, 0, 0, Z, 1, BAD,      2'b00, 0, 0, A1, Z, 0, 0, Z, R1};
    vecs[13] = '{0, 0, 0, Z, 0, 0, 0, Z, 0, Z,        2'b00, 0, 0, A1, Z, 0, 0, Z, R1};

    rst_n = 1'b0;
    applyStimulus('{0, 0, 0, Z, 0, 0, 0, Z, 0, Z, 2'b00, 0, 0, 0, Z, 0, 0, Z, Z});
    #12;
    checkOutput("rst_gnt", gnt, 0);
    checkOutput("rst_mvalid", mem_valid_data, 0);
    checkOutput("rst_maddr", mem_data_addr, 0);
    checkOutput("rst_ready", {req1_ready, req0_ready}, 0);
    checkOutput("rst_error", error, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i]);
      tick();
      checkOutput($sformatf("row%0d_gnt", i), gnt, vecs[i].e_gnt);
      checkOutput($sformatf("row%0d_mvalid", i), mem_valid_data, vecs[i].e_mv);
      checkOutput($sformatf("row%0d_mrw", i), mem_rw_data, vecs[i].e_mrw);
      checkOutput($sformatf("row%0d_maddr", i), mem_data_addr, vecs[i].e_ma);
      checkOutput($sformatf("row%0d_mwr", i), mem_data_wr, vecs[i].e_mwd);
      checkOutput($sformatf("row%0d_r0rdy", i), req0_ready, vecs[i].e_r0rdy);
      checkOutput($sformatf("row%0d_r1rdy", i), req1_ready, vecs[i].e_r1rdy);
      checkOutput($sformatf("row%0d_r0rd", i), req0_rd_data, vecs[i].e_r0rd);
      checkOutput($sformatf("row%0d_r1rd", i), req1_rd_data, vecs[i].e_r1rd);
      checkOutput($sformatf("row%0d_error", i), error, 0);
    end

    // Contention from reset: both hold valid, memory answers on the first BUSY cycle.
    rst_n = 1'b0;
    req0_valid = 1; req0_rw = 1; req0_addr = A0; req0_wr_data = D0;
    req1_valid = 1; req1_rw = 1; req1_addr = A1; req1_wr_data = R1;
    mem_ready_data = 0;
    tick();
    rst_n = 1'b1;
    ng = 0; last_rise = -10; prev_v = 1'b0;
    for (int c = 0; c < 60 && ng < 4; c++) begin
      tick();
      if (req0_ready || req1_ready)
        checkOutput("cont_ready_owner", {req1_ready, req0_ready}, gnt);
      if (mem_valid_data && !prev_v) begin
        order[ng] = gnt;
        checkOutput($sformatf("cont_addr%0d", ng), mem_data_addr, gnt[1] ? A1 : A0);
        if (ng > 0) checkOutput($sformatf("cont_gap%0d_ok", ng), (c - last_rise) >= 3, 1);
        last_rise = c;
        ng++;
      end
      mem_ready_data = mem_valid_data;
      prev_v = mem_valid_data;
    end
    checkOutput("cont_grants_seen", ng, 4);
    if (ng == 4) begin
      checkOutput("cont_order0", order[0], 2'b01);
      checkOutput("cont_order1", order[1], 2'b10);
      checkOutput("cont_order2", order[2], 2'b01);
      checkOutput("cont_order3", order[3], 2'b10);
    end

    // Reset in the middle of a read on port 0, then re-issue.
    mem_ready_data = 0;
    req1_valid = 0;
    req0_valid = 1; req0_rw = 0; req0_addr = A0; req0_wr_data = Z;
    rst_n = 1'b0; #2; rst_n = 1'b1;
    tick();
    checkOutput("mid_busy_gnt", gnt, 2'b01);
    tick();
    #2; rst_n = 1'b0; #1;
    checkOutput("mid_rst_mvalid", mem_valid_data, 0);
    checkOutput("mid_rst_gnt", gnt, 0);
    checkOutput("mid_rst_ready", {req1_ready, req0_ready}, 0);
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("reissue_mvalid", mem_valid_data, 1);
    checkOutput("reissue_gnt", gnt, 2'b01);
    checkOutput("reissue_addr", mem_data_addr, A0);
    checkOutput("reissue_rw", mem_rw_data, 0);
    mem_ready_data = 1; mem_data_rd = R2;
    tick();
    checkOutput("reissue_r0rdy", req0_ready, 1);
    checkOutput("reissue_r0rd", req0_rd_data, R2);
    mem_ready_data = 0; req0_valid = 0;
    tick();
    checkOutput("reissue_r0rdy_drop", req0_ready, 0);

    // Port 1 read that memory never answers.
    req1_valid = 1; req1_rw = 0; req1_addr = A1; req1_wr_data = Z;
    tick();
    checkOutput("hang_gnt", gnt, 2'b10);
`ifdef ARB_TIMEOUT_EN
    got = 1'b0;
    for (int c = 0; c < 300 && !got; c++) begin
      tick();
      got = req1_ready;
    end
    checkOutput("to_ready_seen", got, 1);
    checkOutput("to_rd_data", req1_rd_data, Z);
    checkOutput("to_error", error, 1);
    checkOutput("to_mvalid", mem_valid_data, 0);
    req1_valid = 0;
    repeat (3) tick();
    checkOutput("to_error_sticky", error, 1);
    checkOutput("to_idle_gnt", gnt, 0);
`else
    bad = 1'b0;
    for (int c = 0; c < 300; c++) begin
      tick();
      if (!mem_valid_data || req1_ready || req0_ready || error || gnt != 2'b10) bad = 1'b1;
    end
    checkOutput("hang_persist", bad, 0);
    checkOutput("hang_error", error, 0);
    mem_ready_data = 1; mem_data_rd = R1;
    tick();
    got = req1_ready;
    checkOutput("hang_release_ready", got, 1);
    checkOutput("hang_release_rd", req1_rd_data, R1);
    mem_ready_data = 0; req1_valid = 0;
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
